// File: rtl/mshr_file.sv
// mshr_file: four-entry miss-status holding register file; each miss writes back its victim, then fetches the word on loads.
// Latency: grant the cycle after allocation, bus cycle registered one cycle after grant, completion strobe the cycle after the last ack.
// Backpressure: mshr_full (combinational) stalls the cache; Wishbone wait states hold the cycle until wb_ack_i.
module mshr_file #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mshr_send_pulse,
  input  logic        mshr_lw_in,
  input  logic [31:0] mshr_addr_main,
  input  logic [31:0] mshr_addr_evict,
  input  logic [31:0] evict_data,
  input  logic [31:0] main_data,
  input  logic [4:0]  mshr_regD_in,
  input  logic        way_in,
  output logic        mshr_full,
  output logic [31:0] addr1,
  output logic [31:0] addr2,
  output logic [31:0] addr3,
  output logic [31:0] addr4,
  output logic [31:0] addr5,
  output logic [31:0] addr6,
  output logic [31:0] addr7,
  output logic [31:0] addr8,
  output logic [7:0]  addr_valid,
  output logic        mshr_done_pulse,
  output logic        mshr_done_lw,
  output logic [4:0]  mshr_regD_out,
  output logic [31:0] mshr_addr_out,
  output logic [31:0] mshr_data_out,
  output logic        way_out,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  // Entry indices are two bits wide: the tracking ports are sized for exactly four entries.
  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT_REQ,
    S_EVICT_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_DONE
  } entry_state_e;

  // Per-entry state and latched miss information.
  entry_state_e           state_q [NUM_ENTRIES];
  entry_state_e           state_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] lw_q, lw_d;
  logic [NUM_ENTRIES-1:0] way_q, way_d;
  logic [31:0]            main_q  [NUM_ENTRIES];
  logic [31:0]            main_d  [NUM_ENTRIES];
  logic [31:0]            evict_q [NUM_ENTRIES];
  logic [31:0]            evict_d [NUM_ENTRIES];
  logic [31:0]            edata_q [NUM_ENTRIES];
  logic [31:0]            edata_d [NUM_ENTRIES];
  // Holds store data for stores; overwritten by the fill data on loads.
  logic [31:0]            data_q  [NUM_ENTRIES];
  logic [31:0]            data_d  [NUM_ENTRIES];
  logic [4:0]             regd_q  [NUM_ENTRIES];
  logic [4:0]             regd_d  [NUM_ENTRIES];

  // Shared bus master state.
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [NUM_ENTRIES-1:0] valid, req, done;
  logic                   alloc_vld, grant_vld, ack_vld, done_vld;
  logic [IDX_W-1:0]       alloc_idx, grant_idx, done_idx, rr_idx;
  logic [31:0]            trk [2*NUM_ENTRIES];

  // Decode per-entry status: occupied, waiting for the bus, waiting to retire.
  always_comb begin
    valid = '0;
    req   = '0;
    done  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid[i] = (state_q[i] != S_IDLE);
      req[i]   = (state_q[i] == S_EVICT_REQ) || (state_q[i] == S_FILL_REQ);
      done[i]  = (state_q[i] == S_DONE);
    end
  end

  assign mshr_full = &valid;
  assign alloc_vld = mshr_send_pulse && !mshr_full;
  assign done_vld  = |done;
  assign grant_vld = !cyc_q && (|req);
  // An ack outside a bus cycle is meaningless and must not advance any entry.
  assign ack_vld   = cyc_q && wb_ack_i;

  // Lowest-index free slot takes the next miss; lowest-index finished entry retires first.
  always_comb begin
    alloc_idx = '0;
    done_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IDX_W'(i);
      if (done[i])   done_idx  = IDX_W'(i);
    end
  end

  // Round-robin arbiter: first requester at or after the pointer, wrapping modulo four.
  always_comb begin
    grant_idx = rr_q;
    rr_idx    = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      rr_idx = rr_q + IDX_W'(k);
      if (req[rr_idx]) grant_idx = rr_idx;
    end
  end

  // Per-entry next state: allocate, walk evict/fill through the bus, retire on selection.
  always_comb begin
    lw_d  = lw_q;
    way_d = way_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      main_d[i]  = main_q[i];
      evict_d[i] = evict_q[i];
      edata_d[i] = edata_q[i];
      data_d[i]  = data_q[i];
      regd_d[i]  = regd_q[i];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (alloc_vld && (alloc_idx == IDX_W'(i))) begin
            state_d[i] = S_EVICT_REQ;
            lw_d[i]    = mshr_lw_in;
            way_d[i]   = way_in;
            main_d[i]  = mshr_addr_main;
            evict_d[i] = mshr_addr_evict;
            edata_d[i] = evict_data;
            data_d[i]  = main_data;
            regd_d[i]  = mshr_regD_in;
          end
        end
        S_EVICT_REQ: begin
          if (grant_vld && (grant_idx == IDX_W'(i))) state_d[i] = S_EVICT_WAIT;
        end
        S_EVICT_WAIT: begin
          if (ack_vld && (owner_q == IDX_W'(i))) state_d[i] = lw_q[i] ? S_FILL_REQ : S_DONE;
        end
        S_FILL_REQ: begin
          if (grant_vld && (grant_idx == IDX_W'(i))) state_d[i] = S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (ack_vld && (owner_q == IDX_W'(i))) begin
            state_d[i] = S_DONE;
            data_d[i]  = wb_dat_i;
          end
        end
        S_DONE: begin
          if (done_idx == IDX_W'(i)) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Bus master next state: launch on grant, drop everything the cycle after the ack.
  always_comb begin
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (ack_vld) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end else if (grant_vld) begin
      cyc_d   = 1'b1;
      owner_d = grant_idx;
      rr_d    = grant_idx + IDX_W'(1);
      if (state_q[grant_idx] == S_EVICT_REQ) begin
        we_d  = 1'b1;
        adr_d = evict_q[grant_idx];
        dat_d = edata_q[grant_idx];
      end else begin
        we_d  = 1'b0;
        adr_d = main_q[grant_idx];
        dat_d = '0;
      end
    end
  end

  // Entry registers; reset abandons every outstanding miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_q  <= '0;
      way_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= S_IDLE;
        main_q[i]  <= '0;
        evict_q[i] <= '0;
        edata_q[i] <= '0;
        data_q[i]  <= '0;
        regd_q[i]  <= '0;
      end
    end else begin
      lw_q  <= lw_d;
      way_q <= way_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        main_q[i]  <= main_d[i];
        evict_q[i] <= evict_d[i];
        edata_q[i] <= edata_d[i];
        data_q[i]  <= data_d[i];
        regd_q[i]  <= regd_d[i];
      end
    end
  end

  // Bus registers; reset drops cyc immediately so the slave sees the cycle abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = cyc_q ? 4'hF : 4'h0;

  // Completion outputs are driven only while an entry is retiring; stores report regD as zero.
  always_comb begin
    mshr_done_pulse = done_vld;
    mshr_done_lw    = 1'b0;
    mshr_regD_out   = '0;
    mshr_addr_out   = '0;
    mshr_data_out   = '0;
    way_out         = 1'b0;
    if (done_vld) begin
      mshr_done_lw  = lw_q[done_idx];
      mshr_regD_out = lw_q[done_idx] ? regd_q[done_idx] : 5'd0;
      mshr_addr_out = main_q[done_idx];
      mshr_data_out = data_q[done_idx];
      way_out       = way_q[done_idx];
    end
  end

  // Address tracking for the cache's dependency check: main then evict per entry.
  always_comb begin
    addr_valid = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      trk[2*k]          = valid[k] ? main_q[k]  : 32'd0;
      trk[2*k+1]        = valid[k] ? evict_q[k] : 32'd0;
      addr_valid[2*k]   = valid[k];
      addr_valid[2*k+1] = valid[k];
    end
  end

  assign addr1 = trk[0];
  assign addr2 = trk[1];
  assign addr3 = trk[2];
  assign addr4 = trk[3];
  assign addr5 = trk[4];
  assign addr6 = trk[5];
  assign addr7 = trk[6];
  assign addr8 = trk[7];

endmodule

// File: tb/tb_mshr_file.sv
// tb_mshr_file: scoreboard bench for mshr_file with a behavioural slot model and a Wishbone slave.
// Latency: expectations derive from the allocation/ack cycle numbers recorded by the model.
// Backpressure: the slave inserts fixed or random wait states; the driver respects mshr_full.
module tb_mshr_file;

  logic        clk, rst;
  logic        mshr_send_pulse, mshr_lw_in, way_in;
  logic [31:0] mshr_addr_main, mshr_addr_evict, evict_data, main_data;
  logic [4:0]  mshr_regD_in;
  logic        mshr_full;
  logic [31:0] addr1, addr2, addr3, addr4, addr5, addr6, addr7, addr8;
  logic [7:0]  addr_valid;
  logic        mshr_done_pulse, mshr_done_lw, way_out;
  logic [4:0]  mshr_regD_out;
  logic [31:0] mshr_addr_out, mshr_data_out;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  mshr_file dut (
    .clk(clk), .rst(rst),
    .mshr_send_pulse(mshr_send_pulse), .mshr_lw_in(mshr_lw_in),
    .mshr_addr_main(mshr_addr_main), .mshr_addr_evict(mshr_addr_evict),
    .evict_data(evict_data), .main_data(main_data),
    .mshr_regD_in(mshr_regD_in), .way_in(way_in),
    .mshr_full(mshr_full),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
    .addr5(addr5), .addr6(addr6), .addr7(addr7), .addr8(addr8),
    .addr_valid(addr_valid),
    .mshr_done_pulse(mshr_done_pulse), .mshr_done_lw(mshr_done_lw),
    .mshr_regD_out(mshr_regD_out), .mshr_addr_out(mshr_addr_out),
    .mshr_data_out(mshr_data_out), .way_out(way_out),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr_o [8];
  assign addr_o[0] = addr1;
  assign addr_o[1] = addr2;
  assign addr_o[2] = addr3;
  assign addr_o[3] = addr4;
  assign addr_o[4] = addr5;
  assign addr_o[5] = addr6;
  assign addr_o[6] = addr7;
  assign addr_o[7] = addr8;

  // Model: one record per slot, tracking which bus transfers the miss still owes.
  typedef struct {
    bit          occ;
    bit          lw;
    logic [31:0] main_a;
    logic [31:0] evict_a;
    logic [31:0] edata;
    int          alloc_cyc;
    bit          ev_done;
    bit          fl_done;
    bit          ready;
    int          ready_cyc;
  } slot_t;

  typedef struct {
    int          slot;
    bit          lw;
    logic [4:0]  regd;
    logic [31:0] addr;
    logic [31:0] data;
    bit          way;
  } resp_t;

  slot_t       sb [4];
  resp_t       exp_q [$];
  logic [31:0] bus_log [$];
  int          cur_cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          slave_wait = 2;
  bit          slave_en = 1'b1;
  bit          slave_rand = 1'b0;
  bit          mon_en = 1'b1;
  bit          prev_ack = 1'b0;

  always @(posedge clk) cur_cyc = cur_cyc + 1;

  // Slave memory contents; 0x1004 holds the word the directed load expects.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'h1234_5678;
    return (a ^ 32'hA5A5_0F0F) + 32'h11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cur_cyc);
    end
  endtask

  function automatic bit any_occ();
    for (int i = 0; i < 4; i++) if (sb[i].occ) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int occ_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (sb[i].occ) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) sb[i].occ = 1'b0;
    exp_q.delete();
  endtask

  // Drive a send in the current cycle; the model places it in the lowest free slot unless full.
  task automatic apply_send(input bit lw, input logic [31:0] m, input logic [31:0] e,
                            input logic [31:0] ed, input logic [31:0] md,
                            input logic [4:0] rd, input bit w);
    int s;
    resp_t r;
    mshr_send_pulse = 1'b1;
    mshr_lw_in      = lw;
    mshr_addr_main  = m;
    mshr_addr_evict = e;
    evict_data      = ed;
    main_data       = md;
    mshr_regD_in    = rd;
    way_in          = w;
    s = -1;
    for (int i = 3; i >= 0; i--) if (!sb[i].occ) s = i;
    if (s >= 0) begin
      sb[s].occ       = 1'b1;
      sb[s].lw        = lw;
      sb[s].main_a    = m;
      sb[s].evict_a   = e;
      sb[s].edata     = ed;
      sb[s].alloc_cyc = cur_cyc;
      sb[s].ev_done   = 1'b0;
      sb[s].fl_done   = 1'b0;
      sb[s].ready     = 1'b0;
      sb[s].ready_cyc = 0;
      r.slot = s;
      r.lw   = lw;
      r.regd = lw ? rd : 5'd0;
      r.addr = m;
      r.data = lw ? mem_rd(m) : md;
      r.way  = w;
      exp_q.push_back(r);
    end
  endtask

  task automatic drive_send(input bit lw, input logic [31:0] m, input logic [31:0] e,
                            input logic [31:0] ed, input logic [31:0] md,
                            input logic [4:0] rd, input bit w);
    @(posedge clk);
    #1;
    apply_send(lw, m, e, ed, md, rd, w);
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    mshr_send_pulse = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int t = 0;
    while (any_occ() && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (any_occ()) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d entries outstanding after %0d cycles, expected 0", occ_count(), budget);
    end
    @(negedge clk);
  endtask

  // Wishbone slave: ack after slave_wait wait states, read data from mem_rd.
  initial begin : slave
    int wcnt;
    wcnt = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        if (wb_cyc_o && !wb_ack_i) begin
          if (wcnt >= slave_wait) begin
            wb_ack_i = 1'b1;
            wb_dat_i = wb_we_o ? 32'h0 : mem_rd(wb_adr_o);
            wcnt     = 0;
            if (slave_rand) slave_wait = $urandom_range(0, 3);
          end else begin
            wcnt++;
          end
        end else begin
          wb_ack_i = 1'b0;
          wcnt     = 0;
        end
      end
    end
  end

  // Monitor: compares tracking, completions and bus transfers against the slot model.
  always @(negedge clk) begin : monitor
    int nv, ds, hit;
    bit v;
    if (rst && mon_en) begin
      nv = 0;
      for (int i = 0; i < 4; i++) begin
        v = sb[i].occ && (sb[i].alloc_cyc < cur_cyc);
        if (v) nv++;
        chk("addr_valid", {30'd0, addr_valid[2*i+1], addr_valid[2*i]}, {30'd0, v, v});
        if (v) begin
          chk("addr_main", addr_o[2*i], sb[i].main_a);
          chk("addr_evict", addr_o[2*i+1], sb[i].evict_a);
        end
      end
      chk("mshr_full", {31'd0, mshr_full}, {31'd0, nv == 4});

      ds = -1;
      for (int i = 3; i >= 0; i--)
        if (sb[i].occ && sb[i].ready && (sb[i].ready_cyc < cur_cyc)) ds = i;
      chk("done_pulse", {31'd0, mshr_done_pulse}, {31'd0, ds >= 0});
      if (ds < 0) begin
        chk("idle_done_data", mshr_data_out, 32'd0);
        chk("idle_done_addr", mshr_addr_out, 32'd0);
        chk("idle_done_misc", {25'd0, mshr_done_lw, mshr_regD_out, way_out}, 32'd0);
      end else begin
        hit = -1;
        foreach (exp_q[j]) if (exp_q[j].slot == ds) hit = j;
        if (hit < 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_lookup: slot %0d retiring with no queued response", ds);
        end else begin
          chk("done_lw", {31'd0, mshr_done_lw}, {31'd0, exp_q[hit].lw});
          chk("done_regD", {27'd0, mshr_regD_out}, {27'd0, exp_q[hit].regd});
          chk("done_addr", mshr_addr_out, exp_q[hit].addr);
          chk("done_data", mshr_data_out, exp_q[hit].data);
          chk("done_way", {31'd0, way_out}, {31'd0, exp_q[hit].way});
          exp_q.delete(hit);
        end
        sb[ds].occ = 1'b0;
      end

      if (wb_cyc_o) chk("wb_sel", {28'd0, wb_sel_o}, 32'hF);
      chk("wb_stb", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
      chk("idle_gap", {31'd0, wb_cyc_o && prev_ack}, 32'd0);
      if (wb_cyc_o && wb_ack_i) begin
        bus_log.push_back(wb_adr_o);
        hit = -1;
        if (wb_we_o) begin
          for (int i = 0; i < 4; i++)
            if (sb[i].occ && !sb[i].ev_done && sb[i].evict_a == wb_adr_o) hit = i;
          chk("wr_addr_owed", {31'd0, hit >= 0}, 32'd1);
          if (hit >= 0) begin
            chk("wr_data", wb_dat_o, sb[hit].edata);
            sb[hit].ev_done = 1'b1;
            if (!sb[hit].lw) begin
              sb[hit].ready     = 1'b1;
              sb[hit].ready_cyc = cur_cyc;
            end
          end
        end else begin
          for (int i = 0; i < 4; i++)
            if (sb[i].occ && sb[i].lw && sb[i].ev_done && !sb[i].fl_done && sb[i].main_a == wb_adr_o) hit = i;
          chk("rd_addr_owed", {31'd0, hit >= 0}, 32'd1);
          if (hit >= 0) begin
            sb[hit].fl_done   = 1'b1;
            sb[hit].ready     = 1'b1;
            sb[hit].ready_cyc = cur_cyc;
          end
        end
      end
      prev_ack = wb_cyc_o && wb_ack_i;
    end else begin
      prev_ack = 1'b0;
    end
  end

  initial begin : stim
    int log0, seq, t;
    bit seen;
    rst = 1'b0;
    mshr_send_pulse = 1'b0;
    mshr_lw_in = 1'b0;
    mshr_addr_main = '0;
    mshr_addr_evict = '0;
    evict_data = '0;
    main_data = '0;
    mshr_regD_in = '0;
    way_in = 1'b0;
    clear_model();

    // Outputs under reset.
    #12;
    chk("rst_wb_ctl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
    chk("rst_wb_adr", wb_adr_o, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_done", {24'd0, mshr_done_pulse, mshr_done_lw, mshr_regD_out, way_out}, 32'd0);
    chk("rst_addr_valid_full", {23'd0, addr_valid, mshr_full}, 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_addr", addr_o[i], 32'd0);
    #11 rst = 1'b1;

    // Single load: evict write then fill read, then completion.
    slave_wait = 2;
    log0 = bus_log.size();
    drive_send(1'b1, 32'h0000_1004, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1);
    drive_idle();
    wait_empty(100);
    chk("load_bus_count", bus_log.size() - log0, 32'd2);
    chk("load_wr_adr", bus_log[log0], 32'h0000_2004);
    chk("load_rd_adr", bus_log[log0+1], 32'h0000_1004);
    chk("load_addr_valid_clear", {24'd0, addr_valid}, 32'd0);

    // Store: only the evict write.
    log0 = bus_log.size();
    drive_send(1'b0, 32'h0000_1008, 32'h0000_2008, 32'h1111_2222, 32'hCAFE_0001, 5'd7, 1'b0);
    drive_idle();
    wait_empty(100);
    chk("store_bus_count", bus_log.size() - log0, 32'd1);
    chk("store_wr_adr", bus_log[log0], 32'h0000_2008);

    // Fill all four slots, ignored fifth send, round-robin order, refill of freed slot.
    log0 = bus_log.size();
    for (int k = 0; k < 4; k++)
      drive_send(1'b1, 32'h0000_3000 + 32'(k*16), 32'h0000_4000 + 32'(k*16),
                 32'hE000_0000 + 32'(k), 32'h0, 5'(k+1), k[0]);
    @(posedge clk);
    #1;
    chk("full_after_4", {31'd0, mshr_full}, 32'd1);
    apply_send(1'b1, 32'h0000_3100, 32'h0000_4100, 32'hBAD0_BAD0, 32'h0, 5'd9, 1'b0);
    drive_idle();
    seen = 1'b0;
    t = 0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = mshr_done_pulse;
      t++;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL first_done_timeout: no completion within 200 cycles, expected one");
    end
    @(posedge clk);
    #1;
    chk("full_freed", {31'd0, mshr_full}, 32'd0);
    apply_send(1'b0, 32'h0000_5000, 32'h0000_6000, 32'h5555_6666, 32'h7777_8888, 5'd3, 1'b1);
    drive_idle();
    @(negedge clk);
    chk("refill_slot0", addr1, 32'h0000_5000);
    wait_empty(400);
    chk("rr_grant0", bus_log[log0],   32'h0000_4000);
    chk("rr_grant1", bus_log[log0+1], 32'h0000_4010);
    chk("rr_grant2", bus_log[log0+2], 32'h0000_4020);
    chk("rr_grant3", bus_log[log0+3], 32'h0000_4030);
    chk("rr_grant4", bus_log[log0+4], 32'h0000_3000);

    // Reset during an evict write; a late ack afterwards must not complete anything.
    slave_wait = 3;
    drive_send(1'b0, 32'h0000_7000, 32'h0000_8000, 32'h0102_0304, 32'h0506_0708, 5'd1, 1'b0);
    drive_idle();
    seen = 1'b0;
    t = 0;
    while (!seen && t < 20) begin
      @(negedge clk);
      seen = wb_cyc_o;
      t++;
    end
    chk("midrst_cyc_seen", {31'd0, seen}, 32'd1);
    slave_en = 1'b0;
    wb_ack_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst_addr_valid", {23'd0, addr_valid, mshr_full}, 32'd0);
    clear_model();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 wb_ack_i = 1'b1;
    @(posedge clk);
    #1 wb_ack_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_ack_no_done", {31'd0, mshr_done_pulse}, 32'd0);
    slave_en = 1'b1;

    // Randomised traffic with random wait states.
    slave_rand = 1'b1;
    seq = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 2) == 0) begin
        apply_send(1'($urandom_range(0, 1)), 32'h1000_0000 + 32'(seq*4), 32'h2000_0000 + 32'(seq*4),
                   $urandom, $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
        seq++;
      end else begin
        mshr_send_pulse = 1'b0;
      end
    end
    drive_idle();
    wait_empty(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mshr_file.md
Name: mshr_file

Overview:
- Miss-status holding register file sitting directly downstream of the data cache.
- Accepts one miss per cycle from the cache and holds up to 4 outstanding misses.
- For each miss it writes back the evicted word, then for loads fetches the requested word, all over a single shared Wishbone classic master port.
- Returns one completion per cycle to the cache for line install and, on loads, for register writeback.

Parameters:
- NUM_ENTRIES, 4, entry count; fixed at 4 because the address-tracking ports are sized for 4 entries × 2 addresses.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mshr_send_pulse  in  1  allocate request from cache (1-cycle pulse)
- mshr_lw_in  in  1  1 = load miss, 0 = store miss
- mshr_addr_main  in  32  requested word address
- mshr_addr_evict  in  32  victim word address
- evict_data  in  32  victim data to write back
- main_data  in  32  store data (don't-care for loads)
- mshr_regD_in  in  5  load destination register
- way_in  in  1  cache way to refill
- mshr_full  out  1  combinational; 1 when all 4 entries valid
- addr1..addr8  out  32 each  addr(2k+1) = main addr of entry k, addr(2k+2) = evict addr of entry k
- addr_valid  out  8  bit i qualifies addr(i+1)
- mshr_done_pulse  out  1  completion strobe
- mshr_done_lw  out  1  completing entry was a load
- mshr_regD_out  out  5  completing entry's destination register
- mshr_addr_out  out  32  completing entry's main address
- mshr_data_out  out  32  data to install (load: read data; store: main_data)
- way_out  out  1  completing entry's way
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master control
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  byte select; always 4'hF during a cycle
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - all entries go to IDLE/invalid.
  - All outputs are 0: wb_*, done signals, addr_valid, mshr_full.
  - addr1..8 read 0.
  - An in-flight bus cycle is abandoned; the slave sees cyc drop immediately.
- Per-entry FSM:
  - IDLE --send&&allocated--> EVICT_REQ
  - EVICT_REQ --granted--> EVICT_WAIT (write cycle, adr = evict addr, dat = evict_data)
  - EVICT_WAIT --ack--> FILL_REQ if lw, else DONE
  - FILL_REQ --granted--> FILL_WAIT (read cycle, adr = main addr)
  - FILL_WAIT --ack--> DONE, capture wb_dat_i
  - DONE --selected for completion--> IDLE
- Allocation:
  - on mshr_send_pulse, the lowest-index IDLE entry latches all inputs at the clock edge.
  - A send while mshr_full=1 is ignored and no state changes; the cache guarantees this never happens.
- Freed slots: an entry completing in cycle N is IDLE from N+1. The slot is not reusable in cycle N, because mshr_full is computed from the current valids.
- Address tracking: addr/addr_valid reflect entries in every non-IDLE state, including DONE until it retires.
- Bus arbitration:
  - one transaction outstanding at a time.
  - Among entries in *_REQ states, a round-robin pointer starting at entry 0 selects the grant; the pointer advances past the granted entry.
  - Grant is given only when the bus is idle.
  - cyc/stb/we/adr/dat/sel are registered, asserted the cycle after grant, and held stable until the cycle wb_ack_i=1; they deassert the next cycle.
  - Minimum one idle cycle between transactions.
  - wb_ack_i while not in a cycle is ignored.
- Completion:
  - at most one per cycle; the lowest-index DONE entry wins.
  - For exactly that cycle: mshr_done_pulse=1 and the other done outputs are valid.
  - Other DONE entries wait.
  - With no completion, the done outputs are 0.
- Store completion: mshr_data_out = latched main_data, mshr_done_lw=0, mshr_regD_out=0.
- Simultaneous allocate + completion + ack in one cycle are all honoured independently.
- No merging of same-address misses; the cache stalls on address dependency.

Test Plan:
- Reset then single load:
  - send lw, main=0x0000_1004, evict=0x0000_2004, evict_data=0xDEAD_BEEF, regD=5, way=1.
  - Slave acks each cycle after 2 waits.
  - Required: write 0xDEADBEEF @0x2004, then read @0x1004 returning 0x1234_5678.
  - Then done_pulse with lw=1, regD=5, data=0x12345678, way=1.
  - addr_valid returns to 0.
- Store miss: send sw, main_data=0xCAFE_0001.
  - Required: only the evict write appears on the bus.
  - Then done_pulse, lw=0, data=0xCAFE0001.
- Fill: 4 back-to-back sends → mshr_full=1 after the 4th edge.
  - A 5th send is ignored.
  - After the first completion, mshr_full=0 the following cycle and a new send lands in the freed slot.
- Arbitration: entries 0–3 all requesting → grants in order 0,1,2,3,0.
  - Never two cycles outstanding.
  - wb_sel_o=4'hF throughout.
- Completion ordering: entries 1 and 2 reach DONE in the same cycle.
  - Required: entry 1 done_pulse first, entry 2 the next cycle.
- Reset mid-operation: assert rst during EVICT_WAIT.
  - Required: wb_cyc_o drops asynchronously and all entries are invalid.
  - A late ack after reset release causes no completion.
